nco_sweep_ctrl: RTL and testbench
=================================

# nco_sweep_ctrl

Frequency-sweep sequencer for the `nco` DDS core. It steps the NCO frequency word (`freq_res`) from a start value to a stop value in programmable increments, holding each value for a programmable dwell time, and drives a latched phase offset (`phase`). It sits between the register/config side and the `nco` instance, and its outputs connect directly to the NCO's `freq_res` and `phase` inputs. It supports single-shot and continuous-loop sweeps, abort, and completion signalling.

## Interface
- `FW`, 6: frequency word width; must match `nco.freq_res`.
- `PW`, 8: phase word width; must match `nco.phase`.
- `DW`, 16: dwell counter width.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  starts a sweep when sampled high in IDLE.
- `abort`  in  1  stops the sweep and returns to IDLE; no `done` pulse.
- `loop`  in  1  when 1, restart from `f_start` after reaching `f_stop`; sampled at start.
- `f_start`  in  FW  first frequency word.
- `f_stop`  in  FW  last frequency word.
- `f_step`  in  FW  step magnitude; 0 is treated as 1.
- `dwell`  in  DW  each frequency is held for `dwell`+1 cycles.
- `phase_in`  in  PW  phase offset, latched at start.
- `freq_res`  out  FW  frequency word to the NCO.
- `phase`  out  PW  phase offset to the NCO.
- `busy`  out  1  high while in SWEEP.
- `done`  out  1  one-cycle pulse when a single-shot sweep completes.
- `step_stb`  out  1  one-cycle pulse in each cycle where `freq_res` takes a new value.

## Operation
- States: IDLE, SWEEP, FINISH.
- Transitions:
  - IDLE→SWEEP on `start` & !`abort`.
  - SWEEP→FINISH when the dwell expires at the final value and `loop`=0.
  - SWEEP→IDLE on `abort`.
  - FINISH→IDLE unconditionally.
- At start, latch `f_start`, `f_stop`, `f_step`, `dwell`, `loop` and `phase_in`. Input changes during a sweep have no effect.
- Direction: up if `f_stop` ≥ `f_start`, otherwise down.
- Next value is computed in FW+1 bits: `freq_res` ± step, clamped to `f_stop`. `f_stop` is always emitted exactly, and the value never wraps.
- Dwell counter:
  - Loaded with `dwell` on every new value; decrements each SWEEP cycle.
  - At 0: if `freq_res` == `f_stop`, finish, or reload `f_start` if `loop`=1. Otherwise advance to the next value.
- `f_start` == `f_stop`: one value, held `dwell`+1 cycles, then FINISH (or repeat it if `loop`=1).
- `start` in SWEEP or FINISH is ignored. `abort` in IDLE or FINISH is ignored.
- `abort` and `start` in the same cycle: `abort` wins and the block stays in IDLE.
- After finish or abort, `freq_res` and `phase` hold their last values, so the NCO keeps running.

## Timing
- Reset (`rst_n`=0 at an edge), from any state: next cycle `freq_res`=0, `phase`=0, `busy`=0, `done`=0, `step_stb`=0, state IDLE. A sweep in progress is discarded.
- `start` sampled at edge N: from N+1, `freq_res`=`f_start`, `phase`=`phase_in`, `busy`=1, `step_stb`=1.
- Each value is present for exactly `dwell`+1 cycles. The next value appears with `step_stb`=1 in the following cycle; there are no gap cycles.
- Completion: in the cycle after the final value's last dwell cycle, the block is in FINISH with `done`=1 and `busy`=0. The next cycle is IDLE with `done`=0.
- Loop wrap: `f_start` follows `f_stop` with no gap, and `step_stb`=1.
- `abort` sampled at edge M: `busy`=0 from M+1, `done` stays 0, and `freq_res` is unchanged.

## Configuration
- `NCO_SWEEP_TRIANGLE_EN`
  - Defined: adds input `tri` (1 bit, latched at start). With `tri`=1, reaching `f_stop` reverses direction and steps back toward `f_start` with the same step and clamping; `f_stop` is emitted once. The sweep completes (or loops) on reaching `f_start`.
  - Undefined: no `tri` port; sawtooth sweeps only.

## Test plan
- `f_start`=4, `f_stop`=10, `f_step`=2, `dwell`=3, `loop`=0, start at edge N:
  - `freq_res` is 4 on N+1..N+4, 6 on N+5..N+8, 8 on N+9..N+12, 10 on N+13..N+16.
  - `done`=1 on N+17; `freq_res` stays 10 afterwards.
- Clamp: 1→8, step 3, `dwell`=0 → sequence 1,4,7,8, then `done`. Down sweep: 20→5, step 5, `dwell`=1 → 20,20,15,15,10,10,5,5, then `done`.
- `f_step`=0 with 3→5, `dwell`=0 → 3,4,5. Equal start/stop of 9 with `dwell`=2 → 9 for 3 cycles, then `done`. `start` during a sweep is ignored.
- Loop 0→3, step 1, `dwell`=0 → 0,1,2,3,0,1,… with `busy` held high. `abort` at the cycle showing value 2 → `busy`=0 next cycle, `freq_res`=2 holds, `done` never pulses.
- Reset mid-sweep (`rst_n`=0 for one edge while `freq_res`=6) → all outputs 0 the next cycle; a new `start` then sweeps normally.
- With `NCO_SWEEP_TRIANGLE_EN`: 2→6, step 2, `dwell`=0, `tri`=1 → 2,4,6,4,2, then `done`. With `tri`=0 → 2,4,6, then `done`.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// ============================================================================
// Module   : nco_sweep_ctrl
// Purpose  : Frequency-sweep sequencer driving the freq_res/phase inputs of
//            the nco DDS core (sawtooth; triangle when NCO_SWEEP_TRIANGLE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nco_sweep_ctrl #(
  parameter int FW = 6,
  parameter int PW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          loop,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
`ifdef NCO_SWEEP_TRIANGLE_EN
  // "tri" is a reserved word in SystemVerilog, hence the longer name.
  input  logic          tri_mode,
`endif
  input  logic [PW-1:0] phase_in,
  output logic [FW-1:0] freq_res,
  output logic [PW-1:0] phase,
  output logic          busy,
  output logic          done,
  output logic          step_stb
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_SWEEP  = 2'd1;
  localparam logic [1:0] C_FINISH = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;

  logic [FW-1:0] r_fstart;
  logic [FW-1:0] r_fstop;
  logic [FW-1:0] r_step;
  logic [DW-1:0] r_dwell;
  logic [DW-1:0] r_cnt;
  logic          r_loop;
  logic          r_up;
  logic          r_tri;
  logic          r_ret;
  logic [FW-1:0] r_freq;
  logic [PW-1:0] r_phase;
  logic          r_stb;

  logic          w_tri_in;
  logic          w_launch;
  logic          w_expire;
  logic          w_at_tgt;
  logic          w_reverse;
  logic          w_finish;
  logic [FW-1:0] w_tgt;
  logic          w_dir_up;
  logic [FW-1:0] w_next;

`ifdef NCO_SWEEP_TRIANGLE_EN
  assign w_tri_in = tri_mode;
`else
  assign w_tri_in = 1'b0;
`endif

  // One step toward tgt, computed one bit wider so it clamps rather than wraps.
  function automatic logic [FW-1:0] step_toward(
    input logic [FW-1:0] cur,
    input logic [FW-1:0] stp,
    input logic [FW-1:0] tgt,
    input logic          up
  );
    logic [FW:0] s;
    logic [FW-1:0] r;
    if (up) begin
      s = {1'b0, cur} + {1'b0, stp};
      r = (s >= {1'b0, tgt}) ? tgt : s[FW-1:0];
    end else begin
      s = {1'b0, cur} - {1'b0, stp};
      r = (s[FW] || (s[FW-1:0] <= tgt)) ? tgt : s[FW-1:0];
    end
    return r;
  endfunction

  always_comb begin
    w_launch  = start && !abort;
    w_expire  = (r_cnt == '0);
    w_tgt     = r_ret ? r_fstart : r_fstop;
    w_at_tgt  = (r_freq == w_tgt);
    w_reverse = w_at_tgt && r_tri && !r_ret && (r_fstart != r_fstop);
    w_finish  = w_expire && w_at_tgt && !w_reverse && !r_loop;
    w_dir_up  = (r_ret || w_reverse) ? !r_up : r_up;
    w_next    = step_toward(r_freq, r_step,
                            (r_ret || w_reverse) ? r_fstart : r_fstop, w_dir_up);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE: begin
        if (w_launch) begin
          w_state_nxt = C_SWEEP;
        end
      end
      C_SWEEP: begin
        if (abort) begin
          w_state_nxt = C_IDLE;
        end else if (w_finish) begin
          w_state_nxt = C_FINISH;
        end
      end
      C_FINISH: w_state_nxt = C_IDLE;
      default:  w_state_nxt = C_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state == C_SWEEP);
    done = (r_state == C_FINISH);
  end

  assign freq_res = r_freq;
  assign phase    = r_phase;
  assign step_stb = r_stb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fstart <= '0;
      r_fstop  <= '0;
      r_step   <= '0;
      r_dwell  <= '0;
      r_cnt    <= '0;
      r_loop   <= 1'b0;
      r_up     <= 1'b0;
      r_tri    <= 1'b0;
      r_ret    <= 1'b0;
      r_freq   <= '0;
      r_phase  <= '0;
      r_stb    <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      case (r_state)
        C_IDLE: begin
          if (w_launch) begin
            r_fstart <= f_start;
            r_fstop  <= f_stop;
            r_step   <= (f_step == '0) ? {{(FW-1){1'b0}}, 1'b1} : f_step;
            r_dwell  <= dwell;
            r_cnt    <= dwell;
            r_loop   <= loop;
            r_up     <= (f_stop >= f_start);
            r_tri    <= w_tri_in;
            r_ret    <= 1'b0;
            r_freq   <= f_start;
            r_phase  <= phase_in;
            r_stb    <= 1'b1;
          end
        end
        C_SWEEP: begin
          if (!abort) begin
            if (!w_expire) begin
              r_cnt <= r_cnt - 1'b1;
            end else if (w_at_tgt && !w_reverse) begin
              // End of a pass: restart when looping, otherwise hold for FINISH.
              if (r_loop) begin
                r_freq <= r_fstart;
                r_ret  <= 1'b0;
                r_cnt  <= r_dwell;
                r_stb  <= 1'b1;
              end
            end else begin
              r_freq <= w_next;
              r_ret  <= r_ret || w_reverse;
              r_cnt  <= r_dwell;
              r_stb  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
// ============================================================================
// Module   : tb_nco_sweep_ctrl
// Purpose  : Self-checking bench for nco_sweep_ctrl (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nco_sweep_ctrl;

  localparam int FW = 6;
  localparam int PW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          loop;
  logic [FW-1:0] f_start;
  logic [FW-1:0] f_stop;
  logic [FW-1:0] f_step;
  logic [DW-1:0] dwell;
  logic [PW-1:0] phase_in;
  logic [FW-1:0] freq_res;
  logic [PW-1:0] phase;
  logic          busy;
  logic          done;
  logic          step_stb;

  always #5 clk = ~clk;

  nco_sweep_ctrl #(.FW(FW), .PW(PW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .loop     (loop),
    .f_start  (f_start),
    .f_stop   (f_stop),
    .f_step   (f_step),
    .dwell    (dwell),
    .phase_in (phase_in),
    .freq_res (freq_res),
    .phase    (phase),
    .busy     (busy),
    .done     (done),
    .step_stb (step_stb)
  );

  typedef struct packed {
    logic [FW-1:0]        fs;
    logic [FW-1:0]        fe;
    logic [FW-1:0]        st;
    logic [DW-1:0]        dw;
    logic [PW-1:0]        ph;
    logic [3:0]           n;
    logic [7:0][FW-1:0]   seq;   // seq[0] is the first value
  } vec_t;

  typedef struct packed {
    logic [FW-1:0] freq;
    logic          stb;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Single-shot sweep: scoreboard holds each value repeated dwell+1 times.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   idx;
    for (int k = 0; k < int'(v.n); k++) begin
      for (int d = 0; d <= int'(v.dw); d++) begin
        e.freq = v.seq[k];
        e.stb  = (d == 0);
        sb.push_back(e);
      end
    end
    f_start  = v.fs;
    f_stop   = v.fe;
    f_step   = v.st;
    dwell    = v.dw;
    phase_in = v.ph;
    loop     = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx   = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("freq", freq_res, e.freq);
      check("stb", step_stb, e.stb);
      check("busy", busy, 1);
      check("done_low", done, 0);
      if (idx == 0) check("phase", phase, v.ph);
      // Retrigger and scramble inputs mid-sweep; none of it may take effect.
      if (idx == 1) begin
        start    = 1'b1;
        loop     = 1'b1;
        f_start  = FW'($urandom);
        f_stop   = FW'($urandom);
        f_step   = FW'($urandom);
        dwell    = DW'($urandom_range(0, 5));
        phase_in = PW'($urandom);
      end else begin
        start = 1'b0;
      end
      idx++;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("busy_fin", busy, 0);
    check("freq_hold", freq_res, v.seq[v.n-1]);
    check("phase_hold", phase, v.ph);
    @(negedge clk);
    check("done_clr", done, 0);
    check("busy_idle", busy, 0);
    check("freq_idle", freq_res, v.seq[v.n-1]);
  endtask

  initial begin
    vecs[0] = '{fs: 4,  fe: 10, st: 2,  dw: 3, ph: 8'h5A, n: 4,
                seq: {6'd0, 6'd0, 6'd0, 6'd0, 6'd10, 6'd8, 6'd6, 6'd4}};
    vecs[1] = '{fs: 1,  fe: 8,  st: 3,  dw: 0, ph: 8'h01, n: 4,
                seq: {6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd7, 6'd4, 6'd1}};
    vecs[2] = '{fs: 20, fe: 5,  st: 5,  dw: 1, ph: 8'hC3, n: 4,
                seq: {6'd0, 6'd0, 6'd0, 6'd0, 6'd5, 6'd10, 6'd15, 6'd20}};
    vecs[3] = '{fs: 3,  fe: 5,  st: 0,  dw: 0, ph: 8'h33, n: 3,
                seq: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd5, 6'd4, 6'd3}};
    vecs[4] = '{fs: 9,  fe: 9,  st: 1,  dw: 2, ph: 8'hFF, n: 1,
                seq: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd9}};
    vecs[5] = '{fs: 0,  fe: 63, st: 31, dw: 0, ph: 8'h80, n: 4,
                seq: {6'd0, 6'd0, 6'd0, 6'd0, 6'd63, 6'd62, 6'd31, 6'd0}};
    vecs[6] = '{fs: 63, fe: 0,  st: 40, dw: 1, ph: 8'h7E, n: 3,
                seq: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd23, 6'd63}};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0; phase_in = '0;
    repeat (2) @(negedge clk);
    check("rst_freq", freq_res, 0);
    check("rst_phase", phase, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stb", step_stb, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // start and abort together: abort wins, nothing moves
    f_start = 6'd33; f_stop = 6'd40; f_step = 6'd1; dwell = '0; phase_in = 8'h11;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_freq", freq_res, 0);
    check("sa_stb", step_stb, 0);

    // Continuous loop 0..3 then abort while showing 2 on the second pass
    f_start = 6'd0; f_stop = 6'd3; f_step = 6'd1; dwell = '0; loop = 1'b1;
    phase_in = 8'h42;
    for (int k = 0; k < 6; k++) sb.push_back('{freq: FW'(k % 4), stb: 1'b1});
    sb.push_back('{freq: 6'd2, stb: 1'b1});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; loop = 1'b0;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("loop_freq", freq_res, e.freq);
      check("loop_stb", step_stb, e.stb);
      check("loop_busy", busy, 1);
      if (sb.size() == 0) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("abort_busy", busy, 0);
      check("abort_freq", freq_res, 2);
      check("abort_done", done, 0);
      check("abort_phase", phase, 8'h42);
      @(negedge clk);
    end

    // Reset while freq_res is 6, then a fresh sweep must run normally
    f_start = 6'd4; f_stop = 6'd10; f_step = 6'd2; dwell = 16'd3; phase_in = 8'h99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int waited = 0;
      while (freq_res != 6'd6 && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      check("reach_6", freq_res, 6);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_freq", freq_res, 0);
    check("mid_rst_phase", phase, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_stb", step_stb, 0);
    @(negedge clk);
    check("post_rst_idle", busy, 0);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
